// File: rtl/alu_wide_seq.sv
// alu_wide_seq: multi-byte ADD/SUB/SHL1/XOR sequencer driving an 8-bit combinational ALU, LSB byte first
module alu_wide_seq #(
  parameter int NBYTES = 2,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   cmd,
  input  logic [W-1:0] opnd_a,
  input  logic [W-1:0] opnd_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         flag_c,
  output logic         flag_z,
  output logic         flag_n,
  output logic [3:0]   alu_op,
  output logic         alu_ci,
  output logic [7:0]   alu_in_acc,
  output logic [7:0]   alu_in_a,
  input  logic [7:0]   alu_acc,
  input  logic         alu_co,
  input  logic         alu_z,
  input  logic         alu_neg
);
  localparam logic [3:0] kCLR = 4'd0, kADD = 4'd1, kSUB = 4'd2, kSHL = 4'd3, kXOR = 4'd4;
  localparam logic [1:0] LAST = 2'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, cmd_q, cmd_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic carry_q, carry_d, zacc_q, zacc_d;
  logic busy_q, busy_d, done_q, done_d;
  logic fc_q, fc_d, fz_q, fz_d, fn_q, fn_d;
  logic run, co;
  logic [7:0] byte_a, byte_b;
  always_comb begin
    run = state_q == RUN;
    byte_a = a_q[8*idx_q +: 8];
    byte_b = b_q[8*idx_q +: 8];
    alu_op = !run ? kCLR : cmd_q == 2'd2 ? kSHL : cmd_q == 2'd3 ? kXOR : kADD;
    alu_in_acc = run ? byte_a : 8'd0;
    alu_in_a = !run ? 8'd0 : cmd_q == 2'd2 ? 8'd1 : cmd_q == 2'd1 ? ~byte_b : byte_b;
    // SUB is A + ~B + 1, so the first byte's carry-in provides the +1
    alu_ci = (!run || cmd_q == 2'd3) ? 1'b0 : idx_q == 2'd0 ? cmd_q == 2'd1 : carry_q;
    co = cmd_q != 2'd3 && alu_co;
    state_d = state_q;
    idx_d = idx_q;
    cmd_d = cmd_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    carry_d = carry_q;
    zacc_d = zacc_q;
    fc_d = fc_q;
    fz_d = fz_q;
    fn_d = fn_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      idx_d = 2'd0;
      cmd_d = cmd;
      a_d = opnd_a;
      b_d = opnd_b;
      carry_d = 1'b0;
      zacc_d = 1'b1;
    end else if (run) begin
      result_d[8*idx_q +: 8] = alu_acc;
      carry_d = co;
      zacc_d = zacc_q & alu_z;
      idx_d = idx_q + 2'd1;
      if (idx_q == LAST) begin
        state_d = DONE;
        fc_d = co;
        fz_d = zacc_q & alu_z;
        fn_d = alu_neg;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      cmd_q <= 2'd0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
      zacc_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fc_q <= 1'b0;
      fz_q <= 1'b0;
      fn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cmd_q <= cmd_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      carry_q <= carry_d;
      zacc_q <= zacc_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fc_q <= fc_d;
      fz_q <= fz_d;
      fn_q <= fn_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
  assign flag_c = fc_q;
  assign flag_z = fz_q;
  assign flag_n = fn_q;
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: directed + random checks of alu_wide_seq against a whole-word arithmetic model and a behavioural ALU
module tb_alu_wide_seq;
  localparam int NB = 2;
  localparam int W = 8 * NB;
  localparam logic [3:0] kCLR = 4'd0, kADD = 4'd1, kSUB = 4'd2, kSHL = 4'd3, kXOR = 4'd4;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] cmd = 0;
  logic [W-1:0] opnd_a = 0, opnd_b = 0, result;
  logic busy, done, flag_c, flag_z, flag_n, alu_ci, alu_co, alu_z, alu_neg;
  logic [3:0] alu_op;
  logic [7:0] alu_in_acc, alu_in_a, alu_acc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_wide_seq #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .busy(busy), .done(done), .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .alu_op(alu_op), .alu_ci(alu_ci), .alu_in_acc(alu_in_acc), .alu_in_a(alu_in_a),
    .alu_acc(alu_acc), .alu_co(alu_co), .alu_z(alu_z), .alu_neg(alu_neg)
  );
  // Behavioural 8-bit ALU: kSHL shifts {acc,ci} left by the amount, carry out is the bit shifted past acc[7]
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    if (alu_op == kADD) t = {1'b0, alu_in_acc} + {1'b0, alu_in_a} + {8'd0, alu_ci};
    else if (alu_op == kSUB) t = {1'b0, alu_in_acc - alu_in_a};
    else if (alu_op == kSHL) t = 9'({alu_in_acc, alu_ci} << (alu_in_a - 8'd1));
    else if (alu_op == kXOR) t = {1'b0, alu_in_acc ^ alu_in_a};
    alu_acc = t[7:0];
    alu_co = t[8];
    alu_z = t[7:0] == 8'd0;
    alu_neg = t[7];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic fc);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    case (c)
      2'd0: begin r = full[W-1:0]; fc = full[W]; end
      2'd1: begin r = a - b; fc = a >= b; end
      2'd2: begin r = a << 1; fc = a[W-1]; end
      default: begin r = a ^ b; fc = 1'b0; end
    endcase
  endtask
  task automatic check_result(input logic [W-1:0] er, input logic ec);
    chk("result", result, er);
    chk("flag_c", flag_c, ec);
    chk("flag_z", flag_z, er == '0);
    chk("flag_n", flag_n, er[W-1]);
  endtask
  task automatic run_cmd(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic ec;
    logic [3:0] eop;
    model(c, a, b, er, ec);
    eop = c == 2'd2 ? kSHL : c == 2'd3 ? kXOR : kADD;
    @(negedge clk);
    start = 1; cmd = c; opnd_a = a; opnd_b = b;
    @(posedge clk); #1;
    start = 0; cmd = 2'($urandom); opnd_a = W'($urandom); opnd_b = W'($urandom);
    for (int k = 1; k <= NB + 1; k++) begin
      chk("busy_run", busy, 1);
      chk("done_timing", done, k == NB + 1);
      if (k <= NB) begin
        chk("alu_op_run", alu_op, eop);
        chk("alu_in_acc", alu_in_acc, a[8*(k-1) +: 8]);
        @(posedge clk); #1;
      end
    end
    check_result(er, ec);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
    chk("alu_op_idle", alu_op, kCLR);
  endtask
  initial begin
    logic [W-1:0] er;
    logic ec;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_c, flag_z, flag_n}, 0);
    chk("rst_alu_op", alu_op, kCLR);
    reset = 0;
    run_cmd(2'd0, 16'h00FF, 16'h0001);
    run_cmd(2'd1, 16'h0100, 16'h0001);
    run_cmd(2'd1, 16'h0000, 16'h0001);
    run_cmd(2'd0, 16'h8000, 16'h8000);
    run_cmd(2'd2, 16'h8080, 16'h1234);
    run_cmd(2'd3, 16'hA5A5, 16'hA5A5);
    run_cmd(2'd3, 16'hFF00, 16'h0F0F);
    run_cmd(2'd1, 16'h1234, 16'h1234);
    for (int i = 0; i < 40; i++) run_cmd(2'($urandom), W'($urandom), W'($urandom));
    // start held for 10 edges: accepts at edges 1, 1+(NB+2), ...; done NB cycles after each accept
    model(2'd0, 16'h1234, 16'h4321, er, ec);
    @(negedge clk);
    start = 1; cmd = 2'd0; opnd_a = 16'h1234; opnd_b = 16'h4321;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 10) start = 0;
      chk("held_done", done, (k - NB >= 1) && (k - NB <= 10) && ((k - NB - 1) % (NB + 2) == 0));
      if (done) check_result(er, ec);
    end
    // reset in second RUN cycle
    @(negedge clk);
    start = 1; cmd = 2'd0; opnd_a = 16'h00FF; opnd_b = 16'h0001;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_done", done, 0);
    chk("rstrun_result", result, 0);
    chk("rstrun_flags", {flag_c, flag_z, flag_n}, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rstrun_nodone", done, 0);
    end
    // reset and start together: command dropped
    @(negedge clk);
    reset = 1; start = 1; cmd = 2'd0; opnd_a = 16'h0001; opnd_b = 16'h0001;
    @(posedge clk); #1;
    reset = 0; start = 0;
    chk("rststart_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rststart_idle", busy | done, 0);
    end
    run_cmd(2'd1, 16'h0005, 16'h0007);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
